// File: rtl/qsystd_niosii_cpu_debug_ram_arbiter.sv
// Arbiter sharing the Nios II OCI debug RAM between the JTAG debug slave and a
// host Avalon-MM port. It keeps one access in flight and uses round-robin on ties.
module qsystd_niosii_cpu_debug_ram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        jtag_req,
    input  logic        jtag_write,
    input  logic [7:0]  jtag_addr,
    input  logic [31:0] jtag_wdata,
    input  logic        jtag_clr_overrun,
    output logic [31:0] mon_dreg,
    output logic        mon_ready,
    output logic        jtag_overrun,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [7:0]  av_address,
    input  logic [31:0] av_writedata,
    output logic        av_waitrequest,
    output logic [31:0] av_readdata,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    input  logic [31:0] ram_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, CAPTURE = 2'd3} state_t;

    // Handshakes: the host holds av_read/av_write/av_address/av_writedata stable
    // while av_waitrequest=1, and the transfer completes in the one cycle where
    // av_waitrequest=0. jtag_req is a one-cycle valid that carries its own fields;
    // mon_ready=1 marks completion of the last accepted JTAG command.
    state_t      state, state_next;
    logic        jtag_pend;
    logic        pend_write;
    logic [7:0]  pend_addr;
    logic [31:0] pend_wdata;
    logic        last_grant_host;
    logic        cur_jtag;
    logic        cur_write;

    logic jtag_busy, jtag_drop, jtag_accept, jtag_want, host_want;
    logic grant_jtag, grant_host;
    logic        sel_write;
    logic [7:0]  sel_addr;
    logic [31:0] sel_wdata;

    assign jtag_busy   = (state != IDLE) && cur_jtag;
    assign jtag_drop   = jtag_req && (jtag_pend || jtag_busy);
    assign jtag_accept = jtag_req && !jtag_drop;
    // An accepted jtag_req competes in the same cycle, so a fresh command is not
    // delayed a cycle behind a host request that shows up at the same time.
    assign jtag_want   = jtag_pend || jtag_accept;
    assign host_want   = av_read || av_write;
    assign grant_jtag  = (state == IDLE) && jtag_want && (!host_want || last_grant_host);
    assign grant_host  = (state == IDLE) && host_want && !grant_jtag;

    assign sel_write = jtag_pend ? pend_write : jtag_write;
    assign sel_addr  = jtag_pend ? pend_addr  : jtag_addr;
    assign sel_wdata = jtag_pend ? pend_wdata : jtag_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_jtag || grant_host) state_next = ISSUE;
            ISSUE:   state_next = cur_write ? IDLE : WAIT;
            WAIT:    state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_we         = (state == ISSUE) && cur_write;
        ram_re         = (state == ISSUE) && !cur_write;
        av_waitrequest = 1'b1;
        av_readdata    = 32'h0;
        if (!cur_jtag && state == ISSUE && cur_write) av_waitrequest = 1'b0;
        if (!cur_jtag && state == CAPTURE) begin
            av_waitrequest = 1'b0;
            av_readdata    = ram_rdata;
        end
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jtag_pend       <= 1'b0;
            pend_write      <= 1'b0;
            pend_addr       <= 8'h0;
            pend_wdata      <= 32'h0;
            last_grant_host <= 1'b1;
            cur_jtag        <= 1'b0;
            cur_write       <= 1'b0;
            ram_addr        <= 8'h0;
            ram_wdata       <= 32'h0;
            mon_dreg        <= 32'h0;
            mon_ready       <= 1'b0;
            jtag_overrun    <= 1'b0;
        end else begin
            if (grant_jtag) begin
                cur_jtag        <= 1'b1;
                cur_write       <= sel_write;
                ram_addr        <= sel_addr;
                ram_wdata       <= sel_wdata;
                last_grant_host <= 1'b0;
            end else if (grant_host) begin
                cur_jtag        <= 1'b0;
                cur_write       <= av_write;
                ram_addr        <= av_address;
                ram_wdata       <= av_writedata;
                last_grant_host <= 1'b1;
            end

            if (grant_jtag) begin
                jtag_pend <= 1'b0;
            end else if (jtag_accept) begin
                jtag_pend  <= 1'b1;
                pend_write <= jtag_write;
                pend_addr  <= jtag_addr;
                pend_wdata <= jtag_wdata;
            end

            // A drop in the same cycle as a clear wins, so no lost command goes unreported.
            if (jtag_drop)             jtag_overrun <= 1'b1;
            else if (jtag_clr_overrun) jtag_overrun <= 1'b0;

            if (state == CAPTURE && cur_jtag) mon_dreg <= ram_rdata;

            if (jtag_accept)
                mon_ready <= 1'b0;
            else if (cur_jtag && ((state == ISSUE && cur_write) || state == CAPTURE))
                mon_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qsystd_niosii_cpu_debug_ram_arbiter.sv
// Directed bench for the debug RAM arbiter with a 2-cycle-latency RAM model.
module tb_qsystd_niosii_cpu_debug_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jtag_req = 1'b0;
    logic        jtag_write = 1'b0;
    logic [7:0]  jtag_addr = 8'h0;
    logic [31:0] jtag_wdata = 32'h0;
    logic        jtag_clr_overrun = 1'b0;
    logic [31:0] mon_dreg;
    logic        mon_ready;
    logic        jtag_overrun;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [7:0]  av_address = 8'h0;
    logic [31:0] av_writedata = 32'h0;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata = 32'h0;
    logic [1:0]  dbg_state;

    logic [31:0] mem [256];
    logic [31:0] rd_d1 = 32'h0;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_CAPTURE = 2'd3;

    qsystd_niosii_cpu_debug_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .jtag_req(jtag_req), .jtag_write(jtag_write), .jtag_addr(jtag_addr),
        .jtag_wdata(jtag_wdata), .jtag_clr_overrun(jtag_clr_overrun),
        .mon_dreg(mon_dreg), .mon_ready(mon_ready), .jtag_overrun(jtag_overrun),
        .av_read(av_read), .av_write(av_write), .av_address(av_address),
        .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
        .av_readdata(av_readdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
    );

    // Clock and RAM model: read data appears two cycles after ram_re.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] = ram_wdata;
        if (ram_re) rd_d1 <= mem[ram_addr];
        ram_rdata <= rd_d1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({ram_we, ram_re, ram_addr, ram_wdata} !== 42'h0) begin
            errors++;
            $display("FAIL reset_ram: got we=%b re=%b addr=%h wdata=%h expected all 0", ram_we, ram_re, ram_addr, ram_wdata);
        end
        checks++;
        if ({mon_dreg, mon_ready, jtag_overrun} !== 34'h0) begin
            errors++;
            $display("FAIL reset_mon: got dreg=%h ready=%b overrun=%b expected 0/0/0", mon_dreg, mon_ready, jtag_overrun);
        end
        checks++;
        if (av_waitrequest !== 1'b1 || av_readdata !== 32'h0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_av: got wait=%b rdata=%h state=%0d expected 1/0/0", av_waitrequest, av_readdata, dbg_state);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_jtag_read();
        jtag_req = 1'b1; jtag_write = 1'b0; jtag_addr = 8'h10;
        tick();
        jtag_req = 1'b0;
        checks++;
        if (ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h10) begin
            errors++;
            $display("FAIL jtag_read_issue: got re=%b we=%b addr=%h expected 1/0/10", ram_re, ram_we, ram_addr);
        end
        tick();
        checks++;
        if (ram_re !== 1'b0 || dbg_state !== S_WAIT) begin
            errors++;
            $display("FAIL jtag_read_wait: got re=%b state=%0d expected 0/2", ram_re, dbg_state);
        end
        tick();
        checks++;
        if (av_waitrequest !== 1'b1 || av_readdata !== 32'h0 || mon_ready !== 1'b0) begin
            errors++;
            $display("FAIL jtag_read_capture: got wait=%b rdata=%h ready=%b expected 1/0/0", av_waitrequest, av_readdata, mon_ready);
        end
        tick();
        checks++;
        if (mon_dreg !== 32'hDEADBEEF || mon_ready !== 1'b1) begin
            errors++;
            $display("FAIL jtag_read_done: got dreg=%h ready=%b expected deadbeef/1", mon_dreg, mon_ready);
        end
    endtask

    task automatic test_host_write();
        av_write = 1'b1; av_address = 8'h05; av_writedata = 32'h12345678;
        checks++;
        if (av_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL host_write_grant_wait: got %b expected 1", av_waitrequest);
        end
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 8'h05 || ram_wdata !== 32'h12345678 || av_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL host_write_issue: got we=%b re=%b addr=%h wdata=%h wait=%b expected 1/0/05/12345678/0",
                     ram_we, ram_re, ram_addr, ram_wdata, av_waitrequest);
        end
        av_write = 1'b0;
        tick();
        checks++;
        if (ram_we !== 1'b0 || av_waitrequest !== 1'b1 || mem[5] !== 32'h12345678) begin
            errors++;
            $display("FAIL host_write_after: got we=%b wait=%b mem5=%h expected 0/1/12345678", ram_we, av_waitrequest, mem[5]);
        end
    endtask

    task automatic test_jtag_write();
        jtag_req = 1'b1; jtag_write = 1'b1; jtag_addr = 8'h20; jtag_wdata = 32'hA5A5A5A5;
        tick();
        jtag_req = 1'b0;
        checks++;
        if (ram_we !== 1'b1 || ram_wdata !== 32'hA5A5A5A5 || mon_ready !== 1'b0 || av_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL jtag_write_issue: got we=%b wdata=%h ready=%b wait=%b expected 1/a5a5a5a5/0/1",
                     ram_we, ram_wdata, mon_ready, av_waitrequest);
        end
        tick();
        checks++;
        if (mon_ready !== 1'b1 || mon_dreg !== 32'hDEADBEEF || mem[8'h20] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL jtag_write_done: got ready=%b dreg=%h mem20=%h expected 1/deadbeef/a5a5a5a5", mon_ready, mon_dreg, mem[8'h20]);
        end
    endtask

    task automatic test_overrun();
        jtag_req = 1'b1; jtag_write = 1'b0; jtag_addr = 8'h10;
        tick();
        jtag_write = 1'b1; jtag_addr = 8'h50; jtag_wdata = 32'hFFFFFFFF;
        tick();
        jtag_req = 1'b0;
        checks++;
        if (jtag_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", jtag_overrun);
        end
        tick();
        tick();
        checks++;
        if (mon_ready !== 1'b1 || mon_dreg !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL overrun_first_done: got ready=%b dreg=%h expected 1/deadbeef", mon_ready, mon_dreg);
        end
        tick();
        checks++;
        if (dbg_state !== S_IDLE || mem[8'h50] !== 32'h0 || jtag_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_dropped: got state=%0d mem50=%h overrun=%b expected 0/0/1", dbg_state, mem[8'h50], jtag_overrun);
        end
        jtag_clr_overrun = 1'b1;
        tick();
        jtag_clr_overrun = 1'b0;
        checks++;
        if (jtag_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", jtag_overrun);
        end
        jtag_req = 1'b1; jtag_write = 1'b0; jtag_addr = 8'h10;
        tick();
        jtag_clr_overrun = 1'b1;
        tick();
        jtag_req = 1'b0; jtag_clr_overrun = 1'b0;
        checks++;
        if (jtag_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drop_beats_clear: got %b expected 1", jtag_overrun);
        end
        tick();
        tick();
        jtag_clr_overrun = 1'b1;
        tick();
        jtag_clr_overrun = 1'b0;
    endtask

    task automatic test_tie();
        mem[8'h30] = 32'h11111111;
        mem[8'h31] = 32'h22222222;
        do_reset();
        jtag_req = 1'b1; jtag_write = 1'b0; jtag_addr = 8'h30;
        av_read = 1'b1; av_address = 8'h31;
        tick();
        jtag_req = 1'b0;
        checks++;
        if (ram_re !== 1'b1 || ram_addr !== 8'h30) begin
            errors++;
            $display("FAIL tie1_jtag_first: got re=%b addr=%h expected 1/30", ram_re, ram_addr);
        end
        tick(); tick(); tick();
        checks++;
        if (mon_dreg !== 32'h11111111 || mon_ready !== 1'b1 || av_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL tie1_jtag_done: got dreg=%h ready=%b wait=%b expected 11111111/1/1", mon_dreg, mon_ready, av_waitrequest);
        end
        tick();
        checks++;
        if (ram_re !== 1'b1 || ram_addr !== 8'h31) begin
            errors++;
            $display("FAIL tie1_host_second: got re=%b addr=%h expected 1/31", ram_re, ram_addr);
        end
        tick(); tick();
        checks++;
        if (av_waitrequest !== 1'b0 || av_readdata !== 32'h22222222) begin
            errors++;
            $display("FAIL tie1_host_data: got wait=%b rdata=%h expected 0/22222222", av_waitrequest, av_readdata);
        end
        av_read = 1'b0;
        tick();
        // A lone JTAG write makes JTAG the most recent grant before the second tie.
        jtag_req = 1'b1; jtag_write = 1'b1; jtag_addr = 8'h40; jtag_wdata = 32'h0;
        tick();
        jtag_req = 1'b0;
        tick();
        jtag_req = 1'b1; jtag_write = 1'b0; jtag_addr = 8'h30;
        av_read = 1'b1; av_address = 8'h31;
        tick();
        jtag_req = 1'b0;
        checks++;
        if (ram_re !== 1'b1 || ram_addr !== 8'h31) begin
            errors++;
            $display("FAIL tie2_host_first: got re=%b addr=%h expected 1/31", ram_re, ram_addr);
        end
        tick(); tick();
        checks++;
        if (av_waitrequest !== 1'b0 || av_readdata !== 32'h22222222) begin
            errors++;
            $display("FAIL tie2_host_data: got wait=%b rdata=%h expected 0/22222222", av_waitrequest, av_readdata);
        end
        av_read = 1'b0;
        tick(); tick();
        checks++;
        if (ram_re !== 1'b1 || ram_addr !== 8'h30) begin
            errors++;
            $display("FAIL tie2_jtag_second: got re=%b addr=%h expected 1/30", ram_re, ram_addr);
        end
        tick(); tick(); tick();
        checks++;
        if (mon_dreg !== 32'h11111111 || mon_ready !== 1'b1) begin
            errors++;
            $display("FAIL tie2_jtag_done: got dreg=%h ready=%b expected 11111111/1", mon_dreg, mon_ready);
        end
    endtask

    task automatic test_reset_abort();
        logic bad;
        av_read = 1'b1; av_address = 8'h31;
        tick();
        tick();
        checks++;
        if (dbg_state !== S_WAIT) begin
            errors++;
            $display("FAIL abort_reach_wait: got state=%0d expected 2", dbg_state);
        end
        reset = 1'b1; av_read = 1'b0;
        #1;
        checks++;
        if (av_waitrequest !== 1'b1 || ram_re !== 1'b0 || dbg_state !== S_IDLE || mon_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate: got wait=%b re=%b state=%0d ready=%b expected 1/0/0/0",
                     av_waitrequest, ram_re, dbg_state, mon_ready);
        end
        tick();
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (av_waitrequest !== 1'b1 || av_readdata !== 32'h0 || ram_re !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_readdata: a completion or strobe appeared after the aborted read");
        end
    endtask

    task automatic test_back_to_back();
        int prev_owner;
        int host_cnt;
        int jtag_cnt;
        int owner;
        prev_owner = 1;
        host_cnt = 0;
        jtag_cnt = 0;
        av_read = 1'b1; av_address = 8'h31;
        jtag_write = 1'b0; jtag_addr = 8'h10;
        for (int k = 0; k < 60; k++) begin
            jtag_req = (k % 3 == 0);
            checks++;
            if (ram_we === 1'b1 && ram_re === 1'b1) begin
                errors++;
                $display("FAIL b2b_strobe_overlap: cycle %0d got we=1 re=1 expected at most one", k);
            end
            if (ram_re === 1'b1 || ram_we === 1'b1) begin
                owner = (ram_addr == 8'h10) ? 0 : 1;
                if (owner == 0) jtag_cnt++;
                else            host_cnt++;
                checks++;
                if (owner == prev_owner) begin
                    errors++;
                    $display("FAIL b2b_alternate: cycle %0d got owner=%0d expected %0d", k, owner, 1 - prev_owner);
                end
                prev_owner = owner;
            end
            tick();
        end
        jtag_req = 1'b0;
        av_read = 1'b0;
        checks++;
        if (host_cnt < 6 || jtag_cnt < 6) begin
            errors++;
            $display("FAIL b2b_no_starvation: got host=%0d jtag=%0d expected both >= 6", host_cnt, jtag_cnt);
        end
        tick(); tick(); tick(); tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        test_reset();
        test_jtag_read();
        test_host_write();
        test_jtag_write();
        test_overrun();
        test_tie();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
